// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake. Single-cycle logic/arith/shift ops,
// plus iterative unsigned multiply (shift-add) and restoring divide, one bit per clock.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    typedef enum logic {IDLE, CALC} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor
    logic [WIDTH-1:0] hi, lo;   // product {hi,lo} / remainder hi, quotient lo
    logic             is_div;

    logic             accept, go_iter, last;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum, div_rs, div_diff;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    assign accept  = start && (state == IDLE);
    assign go_iter = accept && ((op == OP_MULU) || ((op == OP_DIVU) && (B != '0)));
    assign last    = (cnt == CW'(1));
    assign shamt   = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration step; the divide borrow bit decides restore vs. subtract.
    always_comb begin
        mul_sum  = {1'b0, hi} + ({1'b0, opnd} & {(WIDTH+1){lo[0]}});
        div_rs   = {hi, lo[WIDTH-1]};
        div_diff = div_rs - {1'b0, opnd};
        hi_nxt   = '0;
        lo_nxt   = '0;
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                hi_nxt = div_diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_rs[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_iter) state_nxt = CALC;
            CALC:    if (last)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            C        <= '0;
            C_hi     <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (accept) begin
                if (go_iter) begin
                    is_div <= (op == OP_DIVU);
                    opnd   <= (op == OP_DIVU) ? B : A;
                    lo     <= (op == OP_DIVU) ? A : B;
                    hi     <= '0;
                    cnt    <= CW'(WIDTH);
                end else if (op == OP_DIVU) begin
                    C        <= '1;
                    C_hi     <= A;
                    div_zero <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    C    <= alu_res;
                    C_hi <= '0;
                    done <= 1'b1;
                end
            end else if (state == CALC) begin
                hi  <= hi_nxt;
                lo  <= lo_nxt;
                cnt <= cnt - CW'(1);
                if (last) begin
                    C    <= lo_nxt;
                    C_hi <= hi_nxt;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: table of single-cycle vectors issued back-to-back,
// then hand-written multi-cycle, mid-op reset and 8-bit instance sequences.
module tb_seq_alu;
    logic        clk, reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B, C, C_hi;
    logic        busy, done, div_zero;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  A8, B8, C8, C_hi8;
    logic        busy8, done8, div_zero8;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .C(C), .C_hi(C_hi), .busy(busy), .done(done), .div_zero(div_zero)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .A(A8), .B(B8),
        .C(C8), .C_hi(C_hi8), .busy(busy8), .done(done8), .div_zero(div_zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, c, hi;
        logic        dz;
    } vec_t;

    vec_t tv[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue a multi-cycle op on the 32-bit instance and check latency and result.
    task automatic run_multi(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ec, input logic [31:0] ehi, input bit poke);
        int k;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        k = 0;
        while (!done && k < 100) begin
            if (poke && k >= 2 && k < 5) begin
                start = 1'b1; op = 4'd0; A = 32'd1; B = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("multi_latency", 64'(k), 64'd32);
        check("multi_C", 64'(C), 64'(ec));
        check("multi_C_hi", 64'(C_hi), 64'(ehi));
        check("multi_div_zero", 64'(div_zero), 64'd0);
        check("multi_busy_at_done", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("multi_done_single_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        int k;
        tv[0]  = '{4'd0, 32'd63,        32'd12,        32'd75,        32'd0, 1'b0};
        tv[1]  = '{4'd1, 32'd12,        32'd63,        32'hFFFFFFCD,  32'd0, 1'b0};
        tv[2]  = '{4'd2, 32'hF0F01234,  32'h0FF0FF00,  32'h00F01200,  32'd0, 1'b0};
        tv[3]  = '{4'd3, 32'hF0000000,  32'h0000000F,  32'hF000000F,  32'd0, 1'b0};
        tv[4]  = '{4'd4, 32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F,  32'd0, 1'b0};
        tv[5]  = '{4'd5, 32'h80000001,  32'd33,        32'h00000002,  32'd0, 1'b0};
        tv[6]  = '{4'd6, 32'h80000000,  32'd4,         32'h08000000,  32'd0, 1'b0};
        tv[7]  = '{4'd7, 32'h80000000,  32'd4,         32'hF8000000,  32'd0, 1'b0};
        tv[8]  = '{4'd7, 32'h40000000,  32'd36,        32'h04000000,  32'd0, 1'b0};
        tv[9]  = '{4'd9, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5, 1'b1};
        tv[10] = '{4'd12, 32'd5,        32'd6,         32'd0,         32'd0, 1'b0};
        tv[11] = '{4'd0, 32'hFFFFFFFF,  32'd1,         32'd0,         32'd0, 1'b0};

        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        start8 = 1'b0; op8 = '0; A8 = '0; B8 = '0;
        repeat (2) @(negedge clk);
        check("rst_C", 64'(C), 64'd0);
        check("rst_C_hi", 64'(C_hi), 64'd0);
        check("rst_flags", 64'({busy, done, div_zero}), 64'd0);
        reset = 1'b1;

        // Back-to-back single-cycle ops: result i is checked while op i+1 is issued.
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("vec%0d_done", i-1), 64'(done), 64'd1);
                check($sformatf("vec%0d_C", i-1), 64'(C), 64'(tv[i-1].c));
                check($sformatf("vec%0d_C_hi", i-1), 64'(C_hi), 64'(tv[i-1].hi));
                check($sformatf("vec%0d_dz", i-1), 64'(div_zero), 64'(tv[i-1].dz));
            end
            if (i < 12) begin
                start = 1'b1; op = tv[i].op; A = tv[i].a; B = tv[i].b;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_done_low", 64'(done), 64'd0);
        check("idle_C_hold", 64'(C), 64'd0);

        run_multi(4'd8, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFE, 32'd1,          1'b1);
        run_multi(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFE,   1'b0);
        run_multi(4'd9, 32'd3,        32'd7,          32'd0,        32'd3,          1'b0);
        run_multi(4'd9, 32'hFFFFFFFF, 32'h10,         32'h0FFFFFFF, 32'hF,          1'b0);
        run_multi(4'd9, 32'd100,      32'd7,          32'd14,       32'd2,          1'b0);

        // Single-cycle op after a multiply/divide must clear C_hi.
        @(negedge clk);
        start = 1'b1; op = 4'd3; A = 32'h10; B = 32'h01;
        @(negedge clk);
        start = 1'b0;
        check("or_after_div_C", 64'(C), 64'h11);
        check("or_after_div_C_hi", 64'(C_hi), 64'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 4'd8; A = 32'd7; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_C", 64'(C), 64'd0);
        check("midrst_C_hi", 64'(C_hi), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) k++;
        end
        check("midrst_no_done", 64'(k), 64'd0);
        start = 1'b1; op = 4'd0; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_add_done", 64'(done), 64'd1);
        check("post_rst_add_C", 64'(C), 64'd2);

        // 8-bit instance: multiply, then a divide issued on the done cycle.
        @(negedge clk);
        start8 = 1'b1; op8 = 4'd8; A8 = 8'd200; B8 = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 50) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("w8_mul_latency", 64'(k), 64'd8);
        check("w8_mul_C", 64'(C8), 64'h40);
        check("w8_mul_C_hi", 64'(C_hi8), 64'h9C);
        start8 = 1'b1; op8 = 4'd9; A8 = 8'd200; B8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_div_accepted", 64'(busy8), 64'd1);
        k = 0;
        while (!done8 && k < 50) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("w8_div_latency", 64'(k), 64'd8);
        check("w8_div_C", 64'(C8), 64'd28);
        check("w8_div_C_hi", 64'(C_hi8), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
